sad_lane_accum: RTL

Consumer of the packed product words produced by the coefficient-multiply stage. Each beat, it takes one pair of 56-bit packed product words: the g-path word (wg) and the f·g-path word (wfg), each holding four 14-bit lanes. It accumulates the per-lane absolute difference over a 16-beat frame, then presents the four lane sums plus the index and value of the minimum lane to the distance-selection logic downstream. It sits directly after the multiply array and before the eye-distance decision stage.

---
 rtl/sad_pkg.sv | 24 ++
 rtl/sad_lane_accum_if.sv | 26 ++
 rtl/sad_lane.sv | 28 ++
 rtl/sad_lane_accum.sv | 86 ++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants and types for the SAD lane accumulator and the multiply stage
// that feeds it.
package sad_pkg;

  localparam int LANES = 4;
  localparam int PW    = 14;
  localparam int BEATS = 16;
  localparam int AW    = PW + $clog2(BEATS);
  localparam int CW    = $clog2(BEATS);
  localparam int IW    = $clog2(LANES);

  typedef logic [PW-1:0] prod_lane_t;
  typedef logic [AW-1:0] acc_lane_t;
  typedef logic [CW-1:0] beat_t;
  typedef logic [IW-1:0] lane_idx_t;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Unsigned |a - b|. The result always fits in PW bits.
  function automatic prod_lane_t abs_diff(input prod_lane_t a, input prod_lane_t b);
    return (a >= b) ? prod_lane_t'(a - b) : prod_lane_t'(b - a);
  endfunction

endpackage

// File: rtl/sad_lane_accum_if.sv
// Input word-pair stream and frame-result stream of the SAD lane accumulator.
interface sad_lane_accum_if;
  import sad_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*PW-1:0]   in_wg;
  logic [LANES*PW-1:0]   in_wfg;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*AW-1:0]   out_sum;
  lane_idx_t             out_min_idx;
  acc_lane_t             out_min;

  // Producer of word pairs and consumer of results.
  modport master (
    output in_valid, in_wg, in_wfg, out_ready,
    input  in_ready, out_valid, out_sum, out_min_idx, out_min
  );

  // The accumulator block itself.
  modport slave (
    input  in_valid, in_wg, in_wfg, out_ready,
    output in_ready, out_valid, out_sum, out_min_idx, out_min
  );
endinterface

// File: rtl/sad_lane.sv
// One lane: absolute difference of two products and an accumulator with
// synchronous clear (priority) and enable.
module sad_lane
  import sad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  prod_lane_t wg,
  input  prod_lane_t wfg,
  output acc_lane_t  sum
);

  acc_lane_t acc;

  // Running total including the current beat; the top samples it on the last beat.
  assign sum = acc + acc_lane_t'(abs_diff(wg, wfg));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/sad_lane_accum.sv
// Accumulates per-lane |wg - wfg| over a BEATS-beat frame, then holds the lane
// sums and the minimum lane until the downstream stage accepts them.
module sad_lane_accum
  import sad_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sad_lane_accum_if.slave bus
);

  state_t              state, state_nxt;
  beat_t               beat;
  logic                fire, last;
  acc_lane_t           sum_nxt [LANES];
  logic [LANES*AW-1:0] sum_pack;
  acc_lane_t           min_val;
  lane_idx_t           min_idx;

  // Handshake outputs come from the state register only.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);

  assign fire = bus.in_valid && (state == ACCUM);
  assign last = fire && (beat == beat_t'(BEATS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sad_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (last),
      .en    (fire),
      .wg    (bus.in_wg[l*PW +: PW]),
      .wfg   (bus.in_wfg[l*PW +: PW]),
      .sum   (sum_nxt[l])
    );
  end

  // Strict less-than scan from lane 0 keeps ties on the lowest index.
  // NOTE: every variable gets a default before any conditional update, so no
  // latch can be inferred.
  always_comb begin
    min_val  = sum_nxt[0];
    min_idx  = '0;
    sum_pack = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_pack[l*AW +: AW] = sum_nxt[l];
      if (sum_nxt[l] < min_val) begin
        min_val = sum_nxt[l];
        min_idx = lane_idx_t'(l);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    beat <= '0;
    else if (last) beat <= '0;
    else if (fire) beat <= beat + beat_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_sum     <= '0;
      bus.out_min_idx <= '0;
      bus.out_min     <= '0;
    end else if (last) begin
      bus.out_sum     <= sum_pack;
      bus.out_min_idx <= min_idx;
      bus.out_min     <= min_val;
    end
  end

endmodule
